// File: rtl/sw_rr_scheduler.sv
// Round-robin scheduler for the switch-index display path: each active requester holds the grant
// for HOLD_CYCLES clocks in turn. Define STICKY_REQ_EN to latch single-cycle request pulses.
module sw_rr_scheduler #(
    parameter int N_REQ       = 8,
    parameter int IDX_W       = 3,
    parameter int HOLD_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] gnt_onehot
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] req_eff;
    logic             last;
    logic [IDX_W-1:0] next_ptr;
    logic [N_REQ-1:0] arb_req;
    logic [IDX_W-1:0] arb_start;
    logic [IDX_W:0]   arb_res;
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;

    // First set bit of r scanning start, start+1, ..., wrapping; returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] start);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (r[IDX_W'(j)]) res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction

    always_comb begin
        last      = (state == GRANT) && (cnt == '0);
        next_ptr  = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        // On the last hold cycle the current owner is masked so another requester gets a turn.
        arb_start = last ? next_ptr : ptr;
        arb_req   = last ? (req_eff & ~gnt_onehot) : req_eff;
        arb_res   = rr_pick(arb_req, arb_start);
        arb_found = arb_res[IDX_W];
        arb_idx   = arb_res[IDX_W-1:0];
    end

`ifdef STICKY_REQ_EN
    logic [N_REQ-1:0] pending;

    // Set wins over the end-of-grant clear, so a pulse arriving on that cycle is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= '0;
        else if (!en)
            pending <= '0;
        else
            pending <= (pending & ~(last ? gnt_onehot : '0)) | req;
    end

    assign req_eff = req | pending;
`else
    assign req_eff = req;
`endif

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else if (!en) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        state      <= GRANT;
                        cnt        <= CNT_W'(HOLD_CYCLES - 1);
                        gnt_valid  <= 1'b1;
                        gnt_idx    <= arb_idx;
                        gnt_onehot <= N_REQ'(1) << arb_idx;
                    end
                end
                GRANT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ptr <= next_ptr;
                        if (arb_found) begin
                            cnt        <= CNT_W'(HOLD_CYCLES - 1);
                            gnt_valid  <= 1'b1;
                            gnt_idx    <= arb_idx;
                            gnt_onehot <= N_REQ'(1) << arb_idx;
                        end else begin
                            state      <= IDLE;
                            gnt_valid  <= 1'b0;
                            gnt_idx    <= '0;
                            gnt_onehot <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
